// File: rtl/img_capture_pkg.sv
// Shared definitions for the image capture front end: FSM encoding,
// error bit positions and frame counter width.
package img_defs;

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VBLANK = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int ERR_SHORT_LINE  = 0;
    localparam int ERR_LONG_LINE   = 1;
    localparam int ERR_SHORT_FRAME = 2;
    localparam int ERR_EXTRA_LINE  = 3;

    localparam int FCW = 16;

endpackage

// File: rtl/img_capture_sync_edge.sv
// One-cycle registered copy of a level input with rise/fall pulses
// derived from the current sample against the previous one.
module sync_edge (
    input  logic clk,
    input  logic reset_1,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q_r;

    // previous-cycle copy of the input
    always_ff @(posedge clk or posedge reset_1) begin
        if (reset_1) begin
            d_q_r <= 1'b0;
        end else begin
            d_q_r <= d;
        end
    end

    assign rise = d & ~d_q_r;
    assign fall = ~d & d_q_r;

endmodule

// File: rtl/img_capture.sv
// Frame-aligning capture of the raw video stream: coordinates, frame
// markers, binarization against a per-frame threshold and geometry checks.
module img_capture
    import img_defs::*;
#(
    parameter int iw = 640,
    parameter int ih = 512,
    parameter int dw = 8,
    parameter int xw = $clog2(iw),
    parameter int yw = $clog2(ih)
) (
    input  logic            clk,
    input  logic            reset_1,
    input  logic [dw-1:0]   dvd,
    input  logic            dvalid,
    input  logic            vsync,
    input  logic [dw-1:0]   thr,
    output logic [dw-1:0]   pix_data,
    output logic            pix_bin,
    output logic            pix_valid,
    output logic [xw-1:0]   pix_x,
    output logic [yw-1:0]   pix_y,
    output logic            sof,
    output logic            eol,
    output logic            eof,
    output logic [FCW-1:0]  frame_cnt,
    output logic [3:0]      err
);

    localparam logic [xw:0] run_lim   = iw[xw:0];
    localparam logic [xw:0] x_last    = run_lim - {{xw{1'b0}}, 1'b1};
    localparam logic [xw:0] run_max   = {(xw+1){1'b1}};
    localparam logic [yw:0] line_lim  = ih[yw:0];
    localparam logic [yw:0] line_last = line_lim - {{yw{1'b0}}, 1'b1};
    localparam logic [yw:0] line_max  = {(yw+1){1'b1}};

    logic dv_rise_s, dv_fall_s, vs_rise_s, vs_fall_s;

    sync_edge u_dv_edge (
        .clk     (clk),
        .reset_1 (reset_1),
        .d       (dvalid),
        .rise    (dv_rise_s),
        .fall    (dv_fall_s)
    );

    sync_edge u_vs_edge (
        .clk     (clk),
        .reset_1 (reset_1),
        .d       (vsync),
        .rise    (vs_rise_s),
        .fall    (vs_fall_s)
    );

    logic [1:0]     state_r, state_s;
    logic [xw:0]    run_r, run_s, idx_s;
    logic [yw:0]    line_r, line_s;
    logic [dw-1:0]  thr_q_r, thr_q_s;
    logic [3:0]     err_s;
    logic [FCW-1:0] fcnt_s;
    logic           valid_s, bin_s, sof_s, eol_s, eof_s;
    logic [dw-1:0]  data_s;
    logic [xw-1:0]  x_s;
    logic [yw-1:0]  y_s;

    // frame FSM, run/line counting, error flags and next output word
    always_comb begin
        state_s = state_r;
        run_s   = run_r;
        line_s  = line_r;
        thr_q_s = thr_q_r;
        err_s   = err;
        fcnt_s  = frame_cnt;
        valid_s = 1'b0;
        data_s  = {dw{1'b0}};
        bin_s   = 1'b0;
        x_s     = {xw{1'b0}};
        y_s     = {yw{1'b0}};
        sof_s   = 1'b0;
        eol_s   = 1'b0;
        eof_s   = 1'b0;
        // a fresh run always starts at column 0, whatever the counter holds
        if (dv_rise_s) begin
            idx_s = {(xw+1){1'b0}};
        end else begin
            idx_s = run_r;
        end

        case (state_r)
            ST_HUNT: begin
                if (vsync) begin
                    state_s = ST_VBLANK;
                end else begin
                    state_s = ST_HUNT;
                end
            end
            ST_VBLANK: begin
                if (vs_fall_s) begin
                    thr_q_s = thr;
                    err_s   = 4'b0000;
                    line_s  = {(yw+1){1'b0}};
                    run_s   = {(xw+1){1'b0}};
                    state_s = ST_ACTIVE;
                end else begin
                    state_s = ST_VBLANK;
                end
            end
            ST_ACTIVE: begin
                if (vs_rise_s) begin
                    err_s[ERR_SHORT_FRAME] = 1'b1;
                    run_s   = {(xw+1){1'b0}};
                    state_s = ST_VBLANK;
                end else if (vsync) begin
                    state_s = ST_ACTIVE;
                end else if (dvalid) begin
                    if (idx_s != run_max) begin
                        run_s = idx_s + {{xw{1'b0}}, 1'b1};
                    end else begin
                        run_s = idx_s;
                    end
                    if (line_r >= line_lim) begin
                        err_s[ERR_EXTRA_LINE] = 1'b1;
                    end else if (idx_s >= run_lim) begin
                        err_s[ERR_LONG_LINE] = 1'b1;
                    end else begin
                        valid_s = 1'b1;
                        data_s  = dvd;
                        bin_s   = (dvd >= thr_q_r);
                        x_s     = idx_s[xw-1:0];
                        y_s     = line_r[yw-1:0];
                        sof_s   = (idx_s == {(xw+1){1'b0}}) && (line_r == {(yw+1){1'b0}});
                        eol_s   = (idx_s == x_last);
                        if ((idx_s == x_last) && (line_r == line_last)) begin
                            eof_s   = 1'b1;
                            fcnt_s  = frame_cnt + 16'd1;
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_ACTIVE;
                        end
                    end
                end else if (dv_fall_s && (run_r != {(xw+1){1'b0}})) begin
                    if (run_r < run_lim) begin
                        err_s[ERR_SHORT_LINE] = 1'b1;
                    end else begin
                        err_s[ERR_SHORT_LINE] = err[ERR_SHORT_LINE];
                    end
                    if (line_r != line_max) begin
                        line_s = line_r + {{yw{1'b0}}, 1'b1};
                    end else begin
                        line_s = line_r;
                    end
                    run_s = {(xw+1){1'b0}};
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            ST_DONE: begin
                if (vs_rise_s) begin
                    state_s = ST_VBLANK;
                end else if (dvalid) begin
                    err_s[ERR_EXTRA_LINE] = 1'b1;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_HUNT;
            end
        endcase
    end

    // state, counters and the single output register stage
    always_ff @(posedge clk or posedge reset_1) begin
        if (reset_1) begin
            state_r   <= ST_HUNT;
            run_r     <= {(xw+1){1'b0}};
            line_r    <= {(yw+1){1'b0}};
            thr_q_r   <= {dw{1'b0}};
            err       <= 4'b0000;
            frame_cnt <= {FCW{1'b0}};
            pix_valid <= 1'b0;
            pix_data  <= {dw{1'b0}};
            pix_bin   <= 1'b0;
            pix_x     <= {xw{1'b0}};
            pix_y     <= {yw{1'b0}};
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
        end else begin
            state_r   <= state_s;
            run_r     <= run_s;
            line_r    <= line_s;
            thr_q_r   <= thr_q_s;
            err       <= err_s;
            frame_cnt <= fcnt_s;
            pix_valid <= valid_s;
            pix_data  <= data_s;
            pix_bin   <= bin_s;
            pix_x     <= x_s;
            pix_y     <= y_s;
            sof       <= sof_s;
            eol       <= eol_s;
            eof       <= eof_s;
        end
    end

endmodule

// File: tb/tb_img_capture.sv
// Directed scoreboard bench for img_capture on a reduced 16x10 image.
module tb_img_capture;

    localparam int IW = 16;
    localparam int IH = 10;

    logic        clk;
    logic        reset_1;
    logic [7:0]  dvd;
    logic        dvalid;
    logic        vsync;
    logic [7:0]  thr;
    logic [7:0]  pix_data;
    logic        pix_bin;
    logic        pix_valid;
    logic [3:0]  pix_x;
    logic [3:0]  pix_y;
    logic        sof;
    logic        eol;
    logic        eof;
    logic [15:0] frame_cnt;
    logic [3:0]  err;

    img_capture #(.iw(IW), .ih(IH), .dw(8)) dut (
        .clk       (clk),
        .reset_1   (reset_1),
        .dvd       (dvd),
        .dvalid    (dvalid),
        .vsync     (vsync),
        .thr       (thr),
        .pix_data  (pix_data),
        .pix_bin   (pix_bin),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .sof       (sof),
        .eol       (eol),
        .eof       (eof),
        .frame_cnt (frame_cnt),
        .err       (err)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       b;
        logic [3:0] x;
        logic [3:0] y;
        logic       s;
        logic       l;
        logic       e;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   pat_mode = 0;
    int   seed = 0;
    logic [7:0] thr_exp = 8'd128;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pix_val(input int x, input int y);
        if (pat_mode == 0) begin
            return 8'((x * 29) + (y * 53) + seed);
        end else begin
            case (x % 4)
                0:       return 8'd127;
                1:       return 8'd128;
                2:       return 8'd50;
                default: return 8'd49;
            endcase
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic send_line(input int npix, input int y, input bit emit);
        exp_t e;
        for (int x = 0; x < npix; x++) begin
            @(posedge clk); #1;
            dvalid = 1'b1;
            dvd    = pix_val(x, y);
            if (emit && (x < IW)) begin
                e.d = dvd;
                e.b = (dvd >= thr_exp);
                e.x = 4'(x);
                e.y = 4'(y);
                e.s = (x == 0) && (y == 0);
                e.l = (x == IW - 1);
                e.e = (x == IW - 1) && (y == IH - 1);
                exp_q.push_back(e);
            end
        end
        @(posedge clk); #1;
        dvalid = 1'b0;
        dvd    = 8'd0;
        repeat (3) @(posedge clk);
    endtask

    task automatic send_lines(input int first, input int last, input bit emit);
        for (int y = first; y <= last; y++) begin
            send_line(IW, y, emit);
        end
    endtask

    task automatic vsync_pulse();
        @(posedge clk); #1;
        vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vsync = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    // monitor: every output strobe is matched against the scoreboard head
    always @(negedge clk) begin
        exp_t got, e;
        if (pix_valid === 1'b1) begin
            got = {pix_data, pix_bin, pix_x, pix_y, sof, eol, eof};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pixel: got d=%0h x=%0d y=%0d sof=%b eol=%b eof=%b, required none",
                         pix_data, pix_x, pix_y, sof, eol, eof);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL pixel: got d=%0h b=%b x=%0d y=%0d sof=%b eol=%b eof=%b, required d=%0h b=%b x=%0d y=%0d sof=%b eol=%b eof=%b",
                             got.d, got.b, got.x, got.y, got.s, got.l, got.e,
                             e.d, e.b, e.x, e.y, e.s, e.l, e.e);
                end
            end
        end else if ((sof | eol | eof) !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL marker_without_valid: got sof=%b eol=%b eof=%b, required 0", sof, eol, eof);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_1 = 1'b1;
        dvd     = 8'd0;
        dvalid  = 1'b0;
        vsync   = 1'b0;
        thr     = 8'd128;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_pix_valid", {31'd0, pix_valid}, 32'd0);
        chk("reset_pix_data",  {24'd0, pix_data}, 32'd0);
        chk("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("reset_err",       {28'd0, err}, 32'd0);

        // reset released partway through a frame: those lines must be ignored
        fork
            send_lines(0, 5, 1'b0);
            begin
                repeat (45) @(posedge clk);
                #3 reset_1 = 1'b0;
            end
        join

        // frames A and B: clean geometry
        vsync_pulse();
        seed = 3;
        send_lines(0, IH - 1, 1'b1);
        @(negedge clk);
        chk("frame_a_cnt", {16'd0, frame_cnt}, 32'd1);
        vsync_pulse();
        seed = 77;
        send_lines(0, IH - 1, 1'b1);
        @(negedge clk);
        chk("frame_b_cnt", {16'd0, frame_cnt}, 32'd2);
        chk("frame_b_err", {28'd0, err}, 32'd0);

        // frame C: short line 5, long line 7, extra run after eof
        vsync_pulse();
        seed = 140;
        send_lines(0, 4, 1'b1);
        send_line(IW - 4, 5, 1'b1);
        @(negedge clk);
        chk("short_line_err", {28'd0, err}, 32'h1);
        send_line(IW, 6, 1'b1);
        send_line(IW + 4, 7, 1'b1);
        @(negedge clk);
        chk("long_line_err", {28'd0, err}, 32'h3);
        send_lines(8, IH - 1, 1'b1);
        @(negedge clk);
        chk("frame_c_cnt", {16'd0, frame_cnt}, 32'd3);
        send_line(5, 0, 1'b0);
        @(negedge clk);
        chk("extra_line_err", {28'd0, err}, 32'hB);

        // frame D: vsync arrives after line 3
        vsync_pulse();
        @(negedge clk);
        chk("frame_d_err_cleared", {28'd0, err}, 32'd0);
        seed = 9;
        send_lines(0, 3, 1'b1);
        @(posedge clk); #1;
        vsync = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("short_frame_err", {28'd0, err}, 32'h4);
        chk("short_frame_cnt", {16'd0, frame_cnt}, 32'd3);
        @(posedge clk); #1;
        vsync = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("after_abort_err", {28'd0, err}, 32'd0);

        // frame E: threshold 128 stays latched though the input changes
        pat_mode = 1;
        thr_exp  = 8'd128;
        send_lines(0, 4, 1'b1);
        thr = 8'd50;
        send_lines(5, IH - 1, 1'b1);
        @(negedge clk);
        chk("frame_e_cnt", {16'd0, frame_cnt}, 32'd4);

        // frame F: threshold 50 takes effect after this vsync fall
        vsync_pulse();
        thr_exp = 8'd50;
        send_lines(0, IH - 1, 1'b1);
        @(negedge clk);
        chk("frame_f_cnt", {16'd0, frame_cnt}, 32'd5);
        chk("frame_f_err", {28'd0, err}, 32'd0);

        // frame G: async reset asserted mid-frame clears everything at once
        pat_mode = 0;
        vsync_pulse();
        send_lines(0, 1, 1'b1);
        @(posedge clk);
        #3 reset_1 = 1'b1;
        #1;
        chk("async_reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("async_reset_valid", {31'd0, pix_valid}, 32'd0);
        chk("async_reset_err", {28'd0, err}, 32'd0);
        repeat (2) @(posedge clk);
        #3 reset_1 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
